// File: rtl/dmem_pkg.sv
// Shared types for the MEM-stage data memory: access codes, FSM states, lane helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_WORD  = 2'b01,
    MEM_BYTE  = 2'b10,
    MEM_UBYTE = 2'b11
  } mem_rd_e;

  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_WORD = 2'b01,
    WR_BYTE = 2'b10,
    WR_RSVD = 2'b11
  } mem_wr_e;

  typedef enum logic [1:0] {
    INIT = 2'b00,
    IDLE = 2'b01,
    WAIT = 2'b10
  } dmem_state_e;

  localparam int unsigned WAIT_CNT_W = 3;

  // Bits needed to select a byte lane inside one word (never below 1).
  function automatic int unsigned lane_idx_w(input int unsigned data_w);
    return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane merge for stores and lane extract with sign/zero extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANE_W = lane_idx_w(DATA_W)
) (
  input  logic [DATA_W-1:0] old_word_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [LANE_W-1:0] lane_i,
  input  mem_rd_e           rd_op_i,
  input  mem_wr_e           wr_op_i,
  output logic [DATA_W-1:0] wr_word_o,
  output logic [DATA_W-1:0] rd_word_o
);

  localparam int unsigned LANES = DATA_W / 8;

  logic [7:0] sel_byte;

  always_comb begin
    wr_word_o = old_word_i;
    case (wr_op_i)
      WR_WORD: wr_word_o = wdata_i;
      WR_BYTE: begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (lane_i == LANE_W'(i)) wr_word_o[i*8 +: 8] = wdata_i[7:0];
        end
      end
      default: wr_word_o = old_word_i;
    endcase
  end

  always_comb begin
    sel_byte = 8'h00;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_i == LANE_W'(i)) sel_byte = old_word_i[i*8 +: 8];
    end
  end

  always_comb begin
    rd_word_o = '0;
    case (rd_op_i)
      MEM_WORD:  rd_word_o = old_word_i;
      MEM_BYTE:  rd_word_o = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
      MEM_UBYTE: rd_word_o = {{(DATA_W-8){1'b0}}, sel_byte};
      default:   rd_word_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_pipe.sv
// MEM-stage data memory: word/byte loads and stores, optional wait states, self zero-fill after reset.
// Define DMEM_MISALIGN_CHECK_EN to suppress and flag misaligned word accesses.
module data_mem_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        memRead,
  input  logic [1:0]        memWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              readValid,
  output logic              stall,
  output logic              initDone,
  output logic              misalign
);

  localparam int unsigned LANE_W = lane_idx_w(DATA_W);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]        init_cnt_q, init_cnt_d;
  logic                    init_done_q, init_done_d;
  logic [DATA_W-1:0]       read_data_q;
  logic                    read_valid_q;
  logic                    misalign_q;
  logic [DATA_W-1:0]       mem_q [DEPTH];

  mem_rd_e                 rd_op_c;
  mem_wr_e                 wr_op_c;
  logic [LANE_W-1:0]       lane_c;
  logic [IDX_W-1:0]        idx_c;
  logic                    has_rd_c, has_wr_c, req_c, mis_c;
  logic                    stall_c, access_c, eff_access_c;
  logic [DATA_W-1:0]       old_word_c, merged_c, load_c;
  logic                    mem_we_c;
  logic [IDX_W-1:0]        mem_waddr_c;
  logic [DATA_W-1:0]       mem_wdata_c;

  // Request decode; word index wraps modulo DEPTH.
  assign rd_op_c  = mem_rd_e'(memRead);
  assign wr_op_c  = mem_wr_e'(memWrite);
  assign lane_c   = LANE_W'(addr);
  assign idx_c    = IDX_W'(addr >> LANE_W);
  assign has_rd_c = (rd_op_c != MEM_NONE);
  assign has_wr_c = (wr_op_c == WR_WORD) || (wr_op_c == WR_BYTE);
  assign req_c    = has_rd_c || has_wr_c;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis_c = ((rd_op_c == MEM_WORD) || (wr_op_c == WR_WORD)) && (lane_c != '0);
`else
  assign mis_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Next-state, stall and access-edge decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    stall_c     = 1'b0;
    access_c    = 1'b0;
    case (state_q)
      INIT: begin
        stall_c    = 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        if (req_c) begin
          if (WAIT_CYCLES == 0) begin
            access_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 1'b1;
        end else begin
          access_c = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        stall_c = 1'b1;
        state_d = INIT;
      end
    endcase
  end

  assign eff_access_c = access_c && !mis_c;
  assign old_word_c   = mem_q[idx_c];

  dmem_lane_align #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_lane_align (
    .old_word_i (old_word_c),
    .wdata_i    (writeData),
    .lane_i     (lane_c),
    .rd_op_i    (rd_op_c),
    .wr_op_i    (wr_op_c),
    .wr_word_o  (merged_c),
    .rd_word_o  (load_c)
  );

  // Single write port shared by the zero-fill sweep and stores.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_waddr_c = idx_c;
    mem_wdata_c = merged_c;
    if (state_q == INIT) begin
      mem_we_c    = 1'b1;
      mem_waddr_c = init_cnt_q;
      mem_wdata_c = '0;
    end else if (eff_access_c && has_wr_c) begin
      mem_we_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
  end

  // Load result is captured from pre-store contents at the access edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      read_valid_q <= eff_access_c && has_rd_c;
      misalign_q   <= access_c && mis_c;
      if (eff_access_c && has_rd_c) read_data_q <= load_c;
    end
  end

  assign readData  = read_data_q;
  assign readValid = read_valid_q;
  assign misalign  = misalign_q;
  assign initDone  = init_done_q;
  assign stall     = stall_c;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Self-checking bench for data_mem_pipe: a zero-wait instance and a two-wait-state instance against a byte-array model.
module tb_data_mem_pipe;

  logic        clk;
  logic        rst, rst_w;
  logic [1:0]  memRead, memWrite, memRead_w, memWrite_w;
  logic [15:0] addr, writeData, addr_w, writeData_w;
  logic [15:0] readData, readData_w;
  logic        readValid, stall, initDone, misalign;
  logic        readValid_w, stall_w, initDone_w, misalign_w;

  int total = 0;
  int bad   = 0;

  // Byte-addressed model: 512 bytes per instance, plus the last load result held.
  logic [7:0]  mdl  [2][512];
  logic [15:0] held [2];

  data_mem_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .addr(addr),
    .writeData(writeData), .readData(readData), .readValid(readValid), .stall(stall),
    .initDone(initDone), .misalign(misalign)
  );

  data_mem_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(2)) dut_w (
    .clk(clk), .rst(rst_w), .memRead(memRead_w), .memWrite(memWrite_w), .addr(addr_w),
    .writeData(writeData_w), .readData(readData_w), .readValid(readValid_w), .stall(stall_w),
    .initDone(initDone_w), .misalign(misalign_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic model_clear(input int w);
    for (int i = 0; i < 512; i++) mdl[w][i] = 8'h00;
    held[w] = 16'h0000;
  endtask

  // Expected outcome of one request from the specification's byte-level rules.
  task automatic model_acc(input int w, input logic [1:0] rd, input logic [1:0] wr,
                           input logic [15:0] a, input logic [15:0] wd,
                           output logic ev, output logic [15:0] ed, output logic em);
    int  b, base;
    bit  mis, req;
    b    = int'(a) % 512;
    base = b - (b % 2);
    req  = (rd != 2'b00) || (wr == 2'b01) || (wr == 2'b10);
    mis  = ((rd == 2'b01) || (wr == 2'b01)) && (b % 2 != 0);
    ev = 1'b0;
    em = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (mis && req) begin
      em = 1'b1;
      req = 1'b0;
    end
`else
    mis = 1'b0;
`endif
    if (req) begin
      if (rd == 2'b01) held[w] = {mdl[w][base+1], mdl[w][base]};
      if (rd == 2'b10) held[w] = {{8{mdl[w][b][7]}}, mdl[w][b]};
      if (rd == 2'b11) held[w] = {8'h00, mdl[w][b]};
      ev = (rd != 2'b00);
      if (wr == 2'b01) begin
        mdl[w][base]   = wd[7:0];
        mdl[w][base+1] = wd[15:8];
      end
      if (wr == 2'b10) mdl[w][b] = wd[7:0];
    end
    ed = held[w];
  endtask

  task automatic drive0(input logic [1:0] rd, input logic [1:0] wr, input logic [15:0] a,
                        input logic [15:0] wd, output logic o_stall, output logic o_valid,
                        output logic o_mis, output logic [15:0] o_data);
    memRead = rd; memWrite = wr; addr = a; writeData = wd;
    #1 o_stall = stall;
    @(posedge clk); #1;
    o_valid = readValid; o_data = readData; o_mis = misalign;
    memRead = 2'b00; memWrite = 2'b00;
  endtask

  // Holds a request on the wait-state instance until it completes.
  task automatic drive_w(input logic [1:0] rd, input logic [1:0] wr, input logic [15:0] a,
                         input logic [15:0] wd, output int n_stall, output logic early_valid,
                         output logic o_valid, output logic [15:0] o_data);
    memRead_w = rd; memWrite_w = wr; addr_w = a; writeData_w = wd;
    n_stall = 0; early_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (stall_w !== 1'b1) break;
      n_stall++;
      @(posedge clk); #1;
      if (readValid_w === 1'b1) early_valid = 1'b1;
    end
    @(posedge clk); #1;
    o_valid = readValid_w; o_data = readData_w;
    memRead_w = 2'b00; memWrite_w = 2'b00;
  endtask

  task automatic wait_init(input int w, output int cycles, output int stall_hi);
    cycles = 0;
    stall_hi = ((w == 0) ? stall : stall_w) === 1'b1 ? 1 : 0;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clk); #1;
      if (((w == 0) ? initDone : initDone_w) === 1'b1) begin
        cycles = n;
        break;
      end
      if (((w == 0) ? stall : stall_w) === 1'b1) stall_hi++;
    end
  endtask

  task automatic test_reset();
    int cyc, shi;
    rst = 1'b1; rst_w = 1'b1;
    memRead = 2'b00; memWrite = 2'b00; addr = '0; writeData = '0;
    memRead_w = 2'b00; memWrite_w = 2'b00; addr_w = '0; writeData_w = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (readData !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", readData); end
    total++; if (readValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", readValid); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall got=%b exp=1", stall); end
    total++; if (initDone !== 1'b0) begin bad++; $display("FAIL reset_initdone got=%b exp=0", initDone); end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
    rst = 1'b0; rst_w = 1'b0;
    model_clear(0); model_clear(1);
    wait_init(0, cyc, shi);
    total++; if (cyc !== 256) begin bad++; $display("FAIL init_cycles got=%0d exp=256", cyc); end
    total++; if (shi !== 256) begin bad++; $display("FAIL init_stall_cycles got=%0d exp=256", shi); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL post_init_stall got=%b exp=0", stall); end
    total++; if (initDone_w !== 1'b1) begin bad++; $display("FAIL init_w_done got=%b exp=1", initDone_w); end
  endtask

  task automatic test_init_loads();
    logic os, ov, om, ev, em; logic [15:0] od, ed;
    for (int i = 0; i < 5; i++) begin
      model_acc(0, 2'b01, 2'b00, 16'(2 * i), 16'h0, ev, ed, em);
      drive0(2'b01, 2'b00, 16'(2 * i), 16'h0, os, ov, om, od);
      total++; if (ov !== 1'b1) begin bad++; $display("FAIL init_load_valid a=%0d got=%b exp=1", 2 * i, ov); end
      total++; if (od !== 16'h0000) begin bad++; $display("FAIL init_load_data a=%0d got=%h exp=0000", 2 * i, od); end
      total++; if (os !== 1'b0) begin bad++; $display("FAIL init_load_stall a=%0d got=%b exp=0", 2 * i, os); end
    end
    @(posedge clk); #1;
    total++; if (readValid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", readValid); end
  endtask

  task automatic test_rbw();
    logic os, ov, om, ev, em; logic [15:0] od, ed;
    model_acc(0, 2'b01, 2'b01, 16'h0000, 16'habcd, ev, ed, em);
    drive0(2'b01, 2'b01, 16'h0000, 16'habcd, os, ov, om, od);
    total++; if (ov !== 1'b1 || od !== 16'h0000) begin bad++; $display("FAIL rbw_old got=%b/%h exp=1/0000", ov, od); end
    model_acc(0, 2'b01, 2'b00, 16'h0000, 16'h0, ev, ed, em);
    drive0(2'b01, 2'b00, 16'h0000, 16'h0, os, ov, om, od);
    total++; if (od !== 16'habcd) begin bad++; $display("FAIL rbw_new got=%h exp=abcd", od); end
  endtask

  task automatic test_byte_lanes();
    logic os, ov, om, ev, em; logic [15:0] od, ed;
    logic [1:0]  rds [4];
    logic [15:0] ads [4];
    logic [15:0] exps [4];
    rds  = '{2'b01, 2'b10, 2'b11, 2'b10};
    ads  = '{16'd2, 16'd3, 16'd3, 16'd2};
    exps = '{16'h9a00, 16'hff9a, 16'h009a, 16'h0000};
    model_acc(0, 2'b00, 2'b10, 16'd3, 16'h0e9a, ev, ed, em);
    drive0(2'b00, 2'b10, 16'd3, 16'h0e9a, os, ov, om, od);
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL bstore_valid got=%b exp=0", ov); end
    for (int i = 0; i < 4; i++) begin
      model_acc(0, rds[i], 2'b00, ads[i], 16'h0, ev, ed, em);
      drive0(rds[i], 2'b00, ads[i], 16'h0, os, ov, om, od);
      total++; if (od !== exps[i]) begin bad++; $display("FAIL byte_lane_%0d got=%h exp=%h", i, od, exps[i]); end
    end
  endtask

  task automatic test_wrap_reserved();
    logic os, ov, om, ev, em; logic [15:0] od, ed;
    model_acc(0, 2'b00, 2'b01, 16'h0200, 16'h1234, ev, ed, em);
    drive0(2'b00, 2'b01, 16'h0200, 16'h1234, os, ov, om, od);
    model_acc(0, 2'b01, 2'b00, 16'h0000, 16'h0, ev, ed, em);
    drive0(2'b01, 2'b00, 16'h0000, 16'h0, os, ov, om, od);
    total++; if (od !== 16'h1234) begin bad++; $display("FAIL wrap got=%h exp=1234", od); end
    model_acc(0, 2'b01, 2'b11, 16'h0000, 16'h5555, ev, ed, em);
    drive0(2'b01, 2'b11, 16'h0000, 16'h5555, os, ov, om, od);
    total++; if (ov !== 1'b1 || od !== 16'h1234) begin bad++; $display("FAIL rsvd_load got=%b/%h exp=1/1234", ov, od); end
    model_acc(0, 2'b01, 2'b00, 16'h0000, 16'h0, ev, ed, em);
    drive0(2'b01, 2'b00, 16'h0000, 16'h0, os, ov, om, od);
    total++; if (od !== 16'h1234) begin bad++; $display("FAIL rsvd_nowrite got=%h exp=1234", od); end
  endtask

  task automatic test_misalign();
    logic os, ov, om, ev, em; logic [15:0] od, ed;
    model_acc(0, 2'b00, 2'b01, 16'h0011, 16'h7e81, ev, ed, em);
    drive0(2'b00, 2'b01, 16'h0011, 16'h7e81, os, ov, om, od);
    total++; if (om !== em) begin bad++; $display("FAIL mis_store_flag got=%b exp=%b", om, em); end
    model_acc(0, 2'b01, 2'b00, 16'h0011, 16'h0, ev, ed, em);
    drive0(2'b01, 2'b00, 16'h0011, 16'h0, os, ov, om, od);
    total++; if (ov !== ev || od !== ed || om !== em) begin bad++; $display("FAIL mis_load got=%b/%h/%b exp=%b/%h/%b", ov, od, om, ev, ed, em); end
    model_acc(0, 2'b01, 2'b00, 16'h0010, 16'h0, ev, ed, em);
    drive0(2'b01, 2'b00, 16'h0010, 16'h0, os, ov, om, od);
    total++; if (od !== ed) begin bad++; $display("FAIL mis_after got=%h exp=%h", od, ed); end
    @(posedge clk); #1;
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL mis_pulse_len got=%b exp=0", misalign); end
  endtask

  task automatic test_random();
    logic os, ov, om, ev, em; logic [15:0] od, ed, a, wd; logic [1:0] rd, wr;
    for (int i = 0; i < 300; i++) begin
      rd = 2'($urandom_range(0, 3));
      wr = 2'($urandom_range(0, 3));
      a  = 16'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a = a | 16'(16'($urandom_range(1, 127)) << 9);
      wd = 16'($urandom);
      model_acc(0, rd, wr, a, wd, ev, ed, em);
      drive0(rd, wr, a, wd, os, ov, om, od);
      total++; if (ov !== ev || od !== ed) begin bad++; $display("FAIL rand_%0d rd=%b wr=%b a=%h got=%b/%h exp=%b/%h", i, rd, wr, a, ov, od, ev, ed); end
      total++; if (om !== em || os !== 1'b0) begin bad++; $display("FAIL rand_ctl_%0d got mis=%b stall=%b exp mis=%b stall=0", i, om, os, em); end
    end
  endtask

  task automatic test_wait_states();
    int ns; logic early, ov, ev, em; logic [15:0] od, ed;
    model_acc(1, 2'b00, 2'b01, 16'd6, 16'h5a3c, ev, ed, em);
    drive_w(2'b00, 2'b01, 16'd6, 16'h5a3c, ns, early, ov, od);
    total++; if (ns !== 2 || ov !== 1'b0) begin bad++; $display("FAIL wait_store got stalls=%0d valid=%b exp 2/0", ns, ov); end
    model_acc(1, 2'b01, 2'b00, 16'd6, 16'h0, ev, ed, em);
    drive_w(2'b01, 2'b00, 16'd6, 16'h0, ns, early, ov, od);
    total++; if (ns !== 2) begin bad++; $display("FAIL wait_stall_cycles got=%0d exp=2", ns); end
    total++; if (early !== 1'b0 || ov !== 1'b1) begin bad++; $display("FAIL wait_valid_timing got early=%b last=%b exp 0/1", early, ov); end
    total++; if (od !== 16'h5a3c) begin bad++; $display("FAIL wait_load got=%h exp=5a3c", od); end
    @(posedge clk); #1;
    total++; if (readValid_w !== 1'b0) begin bad++; $display("FAIL wait_pulse_len got=%b exp=0", readValid_w); end
    model_acc(1, 2'b10, 2'b00, 16'd7, 16'h0, ev, ed, em);
    drive_w(2'b10, 2'b00, 16'd7, 16'h0, ns, early, ov, od);
    total++; if (od !== ed || ov !== ev) begin bad++; $display("FAIL wait_sbyte got=%b/%h exp=%b/%h", ov, od, ev, ed); end
  endtask

  task automatic test_reset_midwait();
    int cyc, shi, ns; logic early, ov, ev, em; logic [15:0] od, ed;
    memRead_w = 2'b00; memWrite_w = 2'b01; addr_w = 16'd4; writeData_w = 16'hbeef;
    #1;
    total++; if (stall_w !== 1'b1) begin bad++; $display("FAIL midwait_stall0 got=%b exp=1", stall_w); end
    @(posedge clk); #1;
    rst_w = 1'b1;
    #1;
    total++; if (stall_w !== 1'b1 || initDone_w !== 1'b0 || readValid_w !== 1'b0) begin bad++; $display("FAIL midwait_reset got stall=%b done=%b valid=%b exp 1/0/0", stall_w, initDone_w, readValid_w); end
    memWrite_w = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_w = 1'b0;
    model_clear(1);
    total++; if (readData_w !== 16'h0000) begin bad++; $display("FAIL midwait_rdata got=%h exp=0000", readData_w); end
    wait_init(1, cyc, shi);
    total++; if (cyc !== 256) begin bad++; $display("FAIL midwait_init got=%0d exp=256", cyc); end
    model_acc(1, 2'b01, 2'b00, 16'd4, 16'h0, ev, ed, em);
    drive_w(2'b01, 2'b00, 16'd4, 16'h0, ns, early, ov, od);
    total++; if (ov !== 1'b1 || od !== 16'h0000) begin bad++; $display("FAIL midwait_nocommit got=%b/%h exp=1/0000", ov, od); end
  endtask

  initial begin
    test_reset();
    test_init_loads();
    test_rbw();
    test_byte_lanes();
    test_wrap_reserved();
    test_misalign();
    test_random();
    test_wait_states();
    test_reset_midwait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
